td4_fetch_seq: RTL and testbench
================================

Name: td4_fetch_seq

Overview:
- Instruction fetch/sequencing controller for the TD4 16-word, 8-bit program ROM.
- Owns the 4-bit program counter and drives the ROM address. Latches the instruction word and issues a one-cycle execute strobe to the datapath.
- Resolves JMP/JNC next-PC.
- Supports free-run, single-step and halt detection.
- Sits between the ROM and the TD4 register/ALU datapath.

Parameters:
RESET_PC, 4'h0, PC value loaded on reset
OP_JMP, 4'hF, opcode (ir[7:4]) of unconditional jump
OP_JNC, 4'hE, opcode of jump-if-carry-clear

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, asynchronous, active-low
run  in  1  level; 1 = continuous execution
step  in  1  single-step request; rising edge executes one instruction
carry  in  1  datapath carry flag, sampled in EXEC
rom_data  in  8  combinational ROM output for rom_addr
rom_addr  out  4  ROM address (= pc)
pc  out  4  current program counter
ir  out  8  latched instruction
exec_en  out  1  one-cycle strobe: ir valid, datapath executes this cycle
halted  out  1  sticky: self-loop JMP detected

Behaviour:
- Reset (RST=0, async): state=IDLE, pc=RESET_PC, ir=8'h00, exec_en=0, halted=0, step_q=0.
- rom_addr = pc at all times (combinational). ROM data is valid in the same cycle.
- step edge detect: step_q registers step; step_rise = step & ~step_q. Sampled in every state, acted on only in IDLE.

FSM, states IDLE, FETCH, EXEC:
- IDLE:
  - halted=1: stay in IDLE; run and step are ignored.
  - Else if run=1: go to FETCH.
  - Else if step_rise: go to FETCH and set single-shot flag ss=1.
  - run and step_rise together: run wins, ss=0.
- FETCH: ir <= rom_data; go to EXEC.
- EXEC: exec_en=1 for exactly this cycle. Next-PC rule:
  - ir[7:4]==OP_JMP: pc <= ir[3:0].
  - ir[7:4]==OP_JNC and carry==0: pc <= ir[3:0].
  - Otherwise: pc <= pc+1, modulo 16 (4'hF wraps to 4'h0; no overflow flag).
  - If ir[7:4]==OP_JMP and ir[3:0]==pc: halted <= 1, pc is unchanged, next state is IDLE.
  - Else if ss=1 or run=0: go to IDLE and clear ss.
  - Else: go to FETCH.
- Throughput: 2 cycles per instruction.
- Latency: run rising in IDLE at cycle N gives FETCH at N+1 and exec_en at N+2.
- run deasserted mid-instruction: the current instruction completes (EXEC), then IDLE. No partial execution.
- step_rise outside IDLE is dropped, not queued.
- A JNC to its own address with carry=0 is NOT a halt; it loops normally.
- Reset mid-EXEC: exec_en drops immediately (async). PC returns to RESET_PC.
- halted clears only on reset.
- pc and ir hold their values in IDLE.

Decomposition:
- Shared package td4_pkg:
  - opcode constants OP_JMP, OP_JNC;
  - state encoding (IDLE=2'd0, FETCH=2'd1, EXEC=2'd2);
  - widths PC_W=4 and INSTR_W=8.
- One natural sub-module: td4_next_pc, a combinational next-PC/halt-detect unit (inputs ir, pc, carry; outputs next_pc, self_loop).
- FSM and registers stay in the top block.

Test Plan:
- Reset, run=1, ROM holds sequential non-jump words: exec_en on every second cycle; pc sequence 0,1,…,F,0 (wrap checked); ir matches the ROM word at each pc.
- ROM[3]=8'hF9 (JMP 9), run=1: after exec of pc=3, next fetch is at 9; exec_en never pulses for pc 4–8.
- ROM[5]=8'hE2 (JNC 2): carry=0 gives next pc=2; carry=1 gives next pc=6.
- ROM[7]=8'hF7 (JMP 7): halted=1 after that EXEC and the FSM stays in IDLE; toggling run and step produces no exec_en; RST low clears halted and pc=0.
- run=0, three step pulses, plus one extra step pulse during EXEC: exactly three exec_en pulses; pc=3; the extra pulse is dropped.
- Assert RST during EXEC with pc=A: exec_en and pc go to 0 asynchronously, before the next CLK edge.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared TD4 fetch-sequencer definitions: datapath widths, jump opcodes and FSM state encoding.
package td4_pkg;

    localparam int unsigned PC_W    = 4;
    localparam int unsigned INSTR_W = 8;
    localparam int unsigned OP_W    = INSTR_W - PC_W;

    localparam logic [OP_W-1:0] OP_JMP = 4'hF;
    localparam logic [OP_W-1:0] OP_JNC = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_e;

    function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1:PC_W];
    endfunction

endpackage

// File: rtl/td4_next_pc.sv
// Combinational next-PC resolution for JMP/JNC plus self-loop (halt) detection.
module td4_next_pc
    import td4_pkg::*;
#(
    parameter logic [OP_W-1:0] OP_JMP = td4_pkg::OP_JMP,
    parameter logic [OP_W-1:0] OP_JNC = td4_pkg::OP_JNC
) (
    input  logic [INSTR_W-1:0] ir,
    input  logic [PC_W-1:0]    pc,
    input  logic               carry,
    output logic [PC_W-1:0]    next_pc,
    output logic               self_loop
);

    logic [OP_W-1:0] op;
    logic [PC_W-1:0] target;
    logic            take_jump;

    always_comb begin
        op        = opcode_of(ir);
        target    = ir[PC_W-1:0];
        take_jump = (op == OP_JMP) || ((op == OP_JNC) && !carry);
        next_pc   = take_jump ? target : pc + PC_W'(1);
        // Only an unconditional jump to itself halts; JNC self-loops keep running.
        self_loop = (op == OP_JMP) && (target == pc);
    end

endmodule

// File: rtl/td4_fetch_seq.sv
// TD4 fetch/sequencing controller: owns the PC, latches the instruction and
// strobes exec_en for one cycle per instruction (IDLE -> FETCH -> EXEC).
module td4_fetch_seq
    import td4_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 4'h0,
    parameter logic [OP_W-1:0] OP_JMP   = td4_pkg::OP_JMP,
    parameter logic [OP_W-1:0] OP_JNC   = td4_pkg::OP_JNC
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               run,
    input  logic               step,
    input  logic               carry,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [PC_W-1:0]    rom_addr,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ir,
    output logic               exec_en,
    output logic               halted
);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               halted_q, halted_d;
    logic               ss_q, ss_d;
    logic               step_q;
    logic               step_rise;
    logic [PC_W-1:0]    next_pc;
    logic               self_loop;

    td4_next_pc #(
        .OP_JMP (OP_JMP),
        .OP_JNC (OP_JNC)
    ) u_next_pc (
        .ir        (ir_q),
        .pc        (pc_q),
        .carry     (carry),
        .next_pc   (next_pc),
        .self_loop (self_loop)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            halted_q <= 1'b0;
            ss_q     <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
            ss_q     <= ss_d;
            step_q   <= step;
        end
    end

    // step edges are tracked in every state so a press held across EXEC is not seen again in IDLE.
    assign step_rise = step & ~step_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        ss_d     = ss_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!halted_q) begin
                    if (run) begin
                        state_d = ST_FETCH;
                        ss_d    = 1'b0;
                    end else if (step_rise) begin
                        state_d = ST_FETCH;
                        ss_d    = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                ir_d    = rom_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (self_loop) begin
                    halted_d = 1'b1;
                    ss_d     = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    pc_d = next_pc;
                    if (ss_q || !run) begin
                        ss_d    = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rom_addr = pc_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign exec_en  = (state_q == ST_EXEC);
    assign halted   = halted_q;

endmodule

// File: tb/tb_td4_fetch_seq.sv
// Directed bench for td4_fetch_seq: an ISA-level model queues expected (pc, ir)
// per executed instruction; a monitor pops and compares on every exec_en.
module tb_td4_fetch_seq;

    logic       CLK;
    logic       RST;
    logic       run;
    logic       step;
    logic       carry;
    logic [7:0] rom_data;
    logic [3:0] rom_addr;
    logic [3:0] pc;
    logic [7:0] ir;
    logic       exec_en;
    logic       halted;

    logic [7:0]  rom [16];
    logic [11:0] sb [$];
    int          checks;
    int          errors;
    int          exec_cnt;

    td4_fetch_seq #(
        .RESET_PC (4'h0),
        .OP_JMP   (4'hF),
        .OP_JNC   (4'hE)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .run      (run),
        .step     (step),
        .carry    (carry),
        .rom_data (rom_data),
        .rom_addr (rom_addr),
        .pc       (pc),
        .ir       (ir),
        .exec_en  (exec_en),
        .halted   (halted)
    );

    assign rom_data = rom[rom_addr];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every executed instruction must match the next queued expectation.
    always @(negedge CLK) begin
        if (RST && exec_en) begin
            logic [11:0] e;
            exec_cnt++;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_exec observed pc=%0h ir=%0h expected none", pc, ir);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("exec_pc", {28'h0, pc}, {28'h0, e[11:8]});
                chk("exec_ir", {24'h0, ir}, {24'h0, e[7:0]});
            end
        end
    end

    task automatic init_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'(8'h10 + i);
    endtask

    task automatic model_push(input int n, input logic [3:0] start, input logic c);
        logic [3:0] p;
        logic [7:0] w;
        p = start;
        for (int i = 0; i < n; i++) begin
            w = rom[p];
            sb.push_back({p, w});
            if (w[7:4] == 4'hF) begin
                if (w[3:0] == p) break;
                p = w[3:0];
            end else if (w[7:4] == 4'hE && !c) begin
                p = w[3:0];
            end else begin
                p = p + 4'd1;
            end
        end
    endtask

    task automatic wait_execs(input int target, input int budget, output int cyc);
        cyc = 0;
        while (exec_cnt < target && cyc < budget) begin
            @(negedge CLK);
            #1;
            cyc++;
        end
        chk("exec_reached", exec_cnt, target);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RST  = 1'b0;
        run  = 1'b0;
        step = 1'b0;
        idle_cycles(2);
        RST = 1'b1;
        idle_cycles(1);
        exec_cnt = 0;
    endtask

    initial begin
        int c1;
        int c2;
        checks   = 0;
        errors   = 0;
        exec_cnt = 0;
        carry    = 1'b1;
        init_rom();

        // Reset state
        do_reset();
        chk("rst_pc", pc, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_ir", ir, 0);
        chk("rst_exec_en", exec_en, 0);
        chk("rst_halted", halted, 0);

        // Free run over sequential words, including the F->0 wrap
        model_push(17, 4'h0, 1'b1);
        run = 1'b1;
        wait_execs(1, 10, c1);
        chk("run_latency", c1, 2);
        wait_execs(17, 60, c2);
        run = 1'b0;
        chk("run_cycles_17", c1 + c2, 34);
        idle_cycles(4);
        chk("run_stop_count", exec_cnt, 17);
        chk("run_stop_pc", pc, 1);
        chk("run_sb_empty", sb.size(), 0);

        // JMP 9 at address 3
        rom[3] = 8'hF9;
        do_reset();
        model_push(10, 4'h0, 1'b1);
        run = 1'b1;
        wait_execs(10, 40, c1);
        run = 1'b0;
        idle_cycles(3);
        chk("jmp_end_pc", pc, 4'hF);
        chk("jmp_sb_empty", sb.size(), 0);

        // JNC 2 at address 5, carry clear then set
        init_rom();
        rom[5] = 8'hE2;
        carry  = 1'b0;
        do_reset();
        model_push(10, 4'h0, 1'b0);
        run = 1'b1;
        wait_execs(10, 40, c1);
        run = 1'b0;
        idle_cycles(3);
        chk("jnc_c0_pc", pc, 2);
        carry = 1'b1;
        do_reset();
        model_push(8, 4'h0, 1'b1);
        run = 1'b1;
        wait_execs(8, 40, c1);
        run = 1'b0;
        idle_cycles(3);
        chk("jnc_c1_pc", pc, 8);
        chk("jnc_sb_empty", sb.size(), 0);

        // JMP 7 at address 7 halts; run/step ignored afterwards
        init_rom();
        rom[7] = 8'hF7;
        do_reset();
        model_push(20, 4'h0, 1'b1);
        run = 1'b1;
        wait_execs(8, 40, c1);
        idle_cycles(4);
        chk("halt_flag", halted, 1);
        chk("halt_pc", pc, 7);
        chk("halt_count", exec_cnt, 8);
        for (int i = 0; i < 3; i++) begin
            run  = 1'b0;
            step = 1'b1;
            idle_cycles(2);
            step = 1'b0;
            run  = 1'b1;
            idle_cycles(2);
        end
        run = 1'b0;
        chk("halt_no_exec", exec_cnt, 8);
        chk("halt_sticky", halted, 1);
        do_reset();
        chk("halt_clr_flag", halted, 0);
        chk("halt_clr_pc", pc, 0);

        // Single step: three pulses, an extra pulse during EXEC is dropped
        init_rom();
        do_reset();
        model_push(3, 4'h0, 1'b1);
        step = 1'b1;
        idle_cycles(1);
        step = 1'b0;
        idle_cycles(4);
        chk("step1_count", exec_cnt, 1);
        step = 1'b1;
        idle_cycles(1);
        step = 1'b0;
        idle_cycles(4);
        step = 1'b1;
        idle_cycles(1);
        step = 1'b0;
        idle_cycles(1);
        chk("step3_in_exec", exec_en, 1);
        step = 1'b1;
        idle_cycles(2);
        step = 1'b0;
        idle_cycles(6);
        chk("step_count", exec_cnt, 3);
        chk("step_pc", pc, 3);
        chk("step_sb_empty", sb.size(), 0);

        // Asynchronous reset in the middle of EXEC at pc=A
        do_reset();
        model_push(11, 4'h0, 1'b1);
        run = 1'b1;
        wait_execs(11, 40, c1);
        chk("mid_exec_en", exec_en, 1);
        chk("mid_exec_pc", pc, 4'hA);
        RST = 1'b0;
        #1;
        chk("async_exec_en", exec_en, 0);
        chk("async_pc", pc, 0);
        chk("async_ir", ir, 0);
        run = 1'b0;
        idle_cycles(2);
        RST = 1'b1;
        idle_cycles(3);
        chk("async_idle_count", exec_cnt, 11);
        chk("final_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
